// File: rtl/serial_char_rx.sv
// 8N1 serial character receiver: synchronizes rxd, deserializes LSB-first bytes,
// optionally folds upper-case ASCII to lower case, and flags bad stop bits.
module serial_char_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit FOLD_CASE    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] char_out,
  output logic       char_valid,
  output logic       frame_err,
  output logic       busy,
  output logic [2:0] state_dbg
);

  // Handshake: char_valid and frame_err are one-cycle strobes with no ready;
  // the consumer must take char_out in the cycle char_valid is high.

  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    sh;
  logic          rxd_m;
  logic          rxd_s;

  function automatic logic [7:0] fold(input logic [7:0] x);
    if (FOLD_CASE && (x >= 8'h41) && (x <= 8'h5A)) return x + 8'h20;
    return x;
  endfunction

  // Synchronizer resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      idx        <= '0;
      sh         <= '0;
      char_out   <= '0;
      char_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      char_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!rxd_s) begin
            state <= S_START;
            cnt   <= '0;
          end
        end
        S_START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            idx <= '0;
            // A start bit that is high again at mid-bit was only a glitch.
            state <= rxd_s ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            sh[idx] <= rxd_s;
            if (idx == 3'd7) state <= S_STOP;
            else             idx   <= idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            // Returning to idle at mid-stop lets a back-to-back start bit be caught.
            if (rxd_s) begin
              char_out   <= fold(sh);
              char_valid <= 1'b1;
              state      <= S_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= S_BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_BREAK: begin
          if (rxd_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule

// File: doc/serial_char_rx.md
# serial_char_rx

Serial character receiver that sits directly upstream of the keyword block checker. It deserializes an asynchronous 8N1 line (idle high, 1 start bit, 8 data bits LSB first, 1 stop bit) into bytes. It optionally folds upper-case ASCII to lower case, and presents each byte with a one-cycle valid strobe so the checker stage consumes exactly one character per frame. It also flags framing errors and blocks re-arming until the line returns to idle.

## Interface

Parameters:
- CLKS_PER_BIT, 16: clock cycles per serial bit; legal values are even and ≥ 4. Define H = CLKS_PER_BIT/2.
- FOLD_CASE, 1: 1 maps 0x41–0x5A to 0x61–0x7A on output; 0 passes bytes unchanged.

Ports (one clock; reset is asynchronous and active-low):
- clk, input, 1: sole clock, rising-edge.
- reset, input, 1: asynchronous, active-low; 0 forces reset state immediately.
- rxd, input, 1: raw serial line, asynchronous to clk, idle 1.
- char_out, output, 8: last correctly framed character (after folding); holds between frames.
- char_valid, output, 1: one-cycle pulse; char_out is new in the same cycle.
- frame_err, output, 1: one-cycle pulse on bad stop bit.
- busy, output, 1: 1 in START/DATA/STOP/BREAK, 0 in IDLE.

## Operation

- rxd passes through a 2-flop synchronizer, giving rxd_s. Synchronizer flops reset to 1.
- The FSM has states IDLE, START, DATA, STOP, BREAK. It uses a bit-timer cnt (width ≥ clog2(CLKS_PER_BIT)), a bit index idx[2:0], and a shift register sh[7:0].
- IDLE: on rxd_s==0, go to START with cnt=0. Otherwise stay.
- START: cnt increments each cycle. When cnt==H-1, sample rxd_s:
  - 0: go to DATA, cnt=0, idx=0.
  - 1: treat as a glitch and return to IDLE. No error is flagged.
- DATA: when cnt==CLKS_PER_BIT-1, sample rxd_s into sh[idx] (LSB first) and set cnt=0. When idx==7, go to STOP; otherwise idx+1.
- STOP: when cnt==CLKS_PER_BIT-1, sample rxd_s:
  - 1: register char_out=fold(sh), pulse char_valid, go to IDLE.
  - 0: pulse frame_err, leave char_out unchanged, go to BREAK.
- BREAK: stay until rxd_s==1, then go to IDLE. A line held low never produces further frames.
- fold(x): x+0x20 if FOLD_CASE==1 and 0x41 ≤ x ≤ 0x5A; else x. Bytes such as 0x5B and 0x40 are never altered.
- char_valid and frame_err are registered, mutually exclusive, and never high for two consecutive cycles.
- Reset values: state=IDLE, cnt=0, idx=0, sh=0, char_out=0x00, char_valid=0, frame_err=0, busy=0.

## Timing

- Pin to FSM: the FSM sees an rxd change 2 rising edges after it is captured.
- Let E0 be the edge at which the FSM leaves IDLE. Sample edges are:
  - start bit: E0+H
  - data bit k: E0+H+(k+1)·CLKS_PER_BIT
  - stop bit: E0+H+9·CLKS_PER_BIT
- char_valid or frame_err is high in the cycle following the stop-sample edge.
- Back-to-back frames: a start bit immediately after the stop bit is accepted, because IDLE is re-entered at mid-stop. No idle gap is required.
- Reset asserted mid-frame: outputs and state clear immediately and asynchronously. The partial byte is discarded. After reset deasserts, reception resumes at the next falling edge of rxd_s.

## Test plan

- CLKS_PER_BIT=16, FOLD_CASE=1, send 0x62 ('b') -> char_out=0x62 with char_valid high for exactly 1 cycle, 2+H+9·16+1 edges after the start edge on the pin; frame_err stays 0.
- Send 0x45 ('E'), then 0x5B ('[') -> char_out 0x65 then 0x5B. With FOLD_CASE=0 the first is 0x45.
- Send "begin " as 6 back-to-back frames with no idle gap -> 6 char_valid pulses exactly 10·16 cycles apart, carrying 0x62 0x65 0x67 0x69 0x6E 0x20.
- Hold the stop bit at 0 for 0x41, then keep the line low 100 cycles -> one frame_err pulse, no char_valid, char_out keeps its prior value, busy=1 until rxd_s returns to 1. Then send 0x64 -> received correctly.
- Drive a 3-cycle low glitch on an idle line -> no char_valid, no frame_err, busy returns to 0 after H cycles.
- Assert reset low at data bit 4 of a frame -> all outputs 0 immediately. Release reset, then send 0x6E -> char_out=0x6E, valid once.
